pim_axi_rd_arbiter: RTL and testbench
=====================================

# pim_axi_rd_arbiter

Two-requester AXI4 read-channel arbiter that shares the single 512-bit read port of the system memory between the CPU instruction/data fetch path (requester 0) and the PIM compute engine (requester 1). It accepts one AR request at a time, forwards it to memory, and routes the whole R burst back to the owner. The grant is locked until the burst's final beat is accepted. It sits between the two masters and the memory slave. Write channels are out of scope and are routed separately.

## Interface
Parameters:
- DATA_WIDTH, 512, R data width
- ADDR_WIDTH, 32, AR address width
- ID_WIDTH, 8, AR/R ID width

Ports:
- clk  input  1  single clock; everything below is synchronous to its rising edge
- rst_n  input  1  asynchronous active-low reset
- sN_arid/araddr/arlen/arsize/arburst  input  ID_WIDTH/ADDR_WIDTH/8/3/2  requester N AR fields, N∈{0,1}
- sN_arvalid  input  1  requester N AR valid
- sN_arready  output  1  requester N AR ready
- sN_rid/rdata/rresp/rlast  output  ID_WIDTH/DATA_WIDTH/2/1  requester N R fields
- sN_rvalid  output  1  requester N R valid
- sN_rready  input  1  requester N R ready
- m_arid/araddr/arlen/arsize/arburst  output  same widths  AR fields to memory
- m_arvalid  output  1  AR valid to memory
- m_arready  input  1  memory AR ready
- m_rid/rdata/rresp/rlast/rvalid  input  same widths  memory R channel
- m_rready  output  1  R ready to memory
- protocol_err  output  1  sticky flag: memory burst length mismatch

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - The winner is chosen combinationally from s0_arvalid and s1_arvalid.
  - Round-robin: `rr_ptr` names the preferred requester. If only one requester is valid, it wins.
  - sN_arready = (state==IDLE) && winner==N. The other requester's arready is 0.
  - On the winner's handshake:
    - Register all AR fields into m_ar*.
    - Record `owner`.
    - Load `beat_cnt` = 0.
    - Go to ADDR.
- ADDR:
  - m_arvalid = 1 with the registered fields, held stable.
  - When m_arready = 1, go to DATA.
- DATA (combinational pass-through):
  - s{owner}_rvalid = m_rvalid. The non-owner's rvalid is 0.
  - m_rready = s{owner}_rready.
  - rid, rdata, rresp and rlast are forwarded unchanged to both requesters.
  - Each R handshake increments `beat_cnt` (8-bit).
  - When the handshake has m_rlast = 1:
    - Go to IDLE.
    - Set rr_ptr = ~owner.
- protocol_err is set, and held until reset, when either of these occurs:
  - a handshake with m_rlast = 1 where beat_cnt != registered arlen;
  - a handshake with m_rlast = 0 where beat_cnt == arlen.
- protocol_err does not alter sequencing. The FSM waits for rlast regardless.
- ID values are not remapped. Ownership comes only from `owner`, since only one burst is ever outstanding.
- m_ar* hold their last values outside ADDR. Only m_arvalid qualifies them.

## Timing
- Reset values:
  - state = IDLE, rr_ptr = 0, owner = 0.
  - All sN_arready = 0, sN_rvalid = 0, m_arvalid = 0, m_rready = 0, protocol_err = 0.
  - m_ar* = 0.
- AR latency:
  - The requester handshake in cycle T gives m_arvalid = 1 from cycle T+1.
  - With m_arready already high, the memory handshake occurs in T+1.
- R path: zero added latency, with no registers in the R path.
- Back-to-back requests:
  - The earliest next sN_arready is the cycle after the final R handshake (state = IDLE).
  - Minimum one idle-gap cycle of AR acceptance per burst.
- Simultaneous arvalid in IDLE: rr_ptr decides. After a burst the other requester is preferred, so neither can be starved for more than one burst.
- A requester dropping arvalid before its handshake is tolerated; re-arbitration happens each IDLE cycle.
- Reset asserted mid-burst: immediate return to the reset state. Any in-flight memory beats are dropped, and the memory must also be reset.

## Configuration
- PIM_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority. Requester 0 wins whenever s0_arvalid = 1 in IDLE, and rr_ptr is unused (held 0).
  - Undefined (default): round-robin as described above.

## Test plan
- Single burst: s0 arlen=3, addr 0x100. Required:
  - m_arvalid one cycle after the s0 handshake with m_araddr=0x100.
  - 4 beats delivered on s0_r* with rlast on beat 4.
  - s1_rvalid stays 0 and protocol_err stays 0.
- Simultaneous request: s0 and s1 arvalid in the same cycle after reset. Required:
  - s0 granted first.
  - After s0's rlast, s1 is granted, with s1_arready one cycle after the final beat.
- Starvation: s0 and s1 both request continuously for 6 bursts. Required: grants alternate 0,1,0,1,0,1. With PIM_ARB_FIXED_PRIO_EN defined, all 6 grants go to s0.
- Backpressure: s1 burst arlen=7 with s1_rready toggling every cycle. Required:
  - m_rready mirrors s1_rready.
  - 8 beats are delivered in order with no data loss.
- Length mismatch: memory model asserts rlast on beat 2 of an arlen=3 burst. Required:
  - protocol_err=1 from the next cycle and stays set.
  - FSM returns to IDLE.
- Reset during DATA: rst_n low mid-burst. Required: all outputs return to reset values in the same cycle, and a fresh s1 request afterwards completes normally.

Source files
------------

// File: rtl/pim_axi_rd_arbiter.sv
// pim_axi_rd_arbiter: two-requester AXI4 read-channel arbiter with a grant locked for a whole R burst.
// Define PIM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 first); the default build is round-robin.
module pim_axi_rd_arbiter #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // requester 0 (CPU fetch path)
    input  logic [ID_WIDTH-1:0]   s0_arid,
    input  logic [ADDR_WIDTH-1:0] s0_araddr,
    input  logic [7:0]            s0_arlen,
    input  logic [2:0]            s0_arsize,
    input  logic [1:0]            s0_arburst,
    input  logic                  s0_arvalid,
    output logic                  s0_arready,
    output logic [ID_WIDTH-1:0]   s0_rid,
    output logic [DATA_WIDTH-1:0] s0_rdata,
    output logic [1:0]            s0_rresp,
    output logic                  s0_rlast,
    output logic                  s0_rvalid,
    input  logic                  s0_rready,
    // requester 1 (PIM compute engine)
    input  logic [ID_WIDTH-1:0]   s1_arid,
    input  logic [ADDR_WIDTH-1:0] s1_araddr,
    input  logic [7:0]            s1_arlen,
    input  logic [2:0]            s1_arsize,
    input  logic [1:0]            s1_arburst,
    input  logic                  s1_arvalid,
    output logic                  s1_arready,
    output logic [ID_WIDTH-1:0]   s1_rid,
    output logic [DATA_WIDTH-1:0] s1_rdata,
    output logic [1:0]            s1_rresp,
    output logic                  s1_rlast,
    output logic                  s1_rvalid,
    input  logic                  s1_rready,
    // memory slave
    output logic [ID_WIDTH-1:0]   m_arid,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [7:0]            m_arlen,
    output logic [2:0]            m_arsize,
    output logic [1:0]            m_arburst,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [ID_WIDTH-1:0]   m_rid,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    output logic                  protocol_err
);

    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_e;

    state_e                state_q, state_d;
    logic                  rr_ptr_q, rr_ptr_d;
    logic                  owner_q, owner_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic                  err_q, err_d;
    logic [ID_WIDTH-1:0]   arid_q, arid_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]            arlen_q, arlen_d;
    logic [2:0]            arsize_q, arsize_d;
    logic [1:0]            arburst_q, arburst_d;
    logic                  winner;
    logic                  any_valid;
    logic                  owner_rready;
    logic                  r_hs;

    assign any_valid = s0_arvalid | s1_arvalid;

`ifdef PIM_ARB_FIXED_PRIO_EN
    assign winner = ~s0_arvalid;
`else
    // Contention is settled by rr_ptr; otherwise the lone valid requester wins.
    assign winner = (s0_arvalid & s1_arvalid) ? rr_ptr_q : s1_arvalid;
`endif

    // Valid/ready: a transfer happens on a channel in any cycle where its valid and ready are both high.
    assign s0_arready = (state_q == IDLE) & s0_arvalid & ~winner;
    assign s1_arready = (state_q == IDLE) & s1_arvalid & winner;

    assign m_arvalid = (state_q == ADDR);
    assign m_arid    = arid_q;
    assign m_araddr  = araddr_q;
    assign m_arlen   = arlen_q;
    assign m_arsize  = arsize_q;
    assign m_arburst = arburst_q;

    // R path is purely combinational; only one burst is ever outstanding, so owner_q routes it.
    assign owner_rready = owner_q ? s1_rready : s0_rready;
    assign m_rready     = (state_q == DATA) & owner_rready;
    assign s0_rvalid    = (state_q == DATA) & ~owner_q & m_rvalid;
    assign s1_rvalid    = (state_q == DATA) & owner_q & m_rvalid;
    assign r_hs         = m_rvalid & m_rready;

    assign s0_rid   = m_rid;
    assign s0_rdata = m_rdata;
    assign s0_rresp = m_rresp;
    assign s0_rlast = m_rlast;
    assign s1_rid   = m_rid;
    assign s1_rdata = m_rdata;
    assign s1_rresp = m_rresp;
    assign s1_rlast = m_rlast;

    assign protocol_err = err_q;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        arid_d     = arid_q;
        araddr_d   = araddr_q;
        arlen_d    = arlen_q;
        arsize_d   = arsize_q;
        arburst_d  = arburst_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    owner_d    = winner;
                    beat_cnt_d = 8'd0;
                    arid_d     = winner ? s1_arid    : s0_arid;
                    araddr_d   = winner ? s1_araddr  : s0_araddr;
                    arlen_d    = winner ? s1_arlen   : s0_arlen;
                    arsize_d   = winner ? s1_arsize  : s0_arsize;
                    arburst_d  = winner ? s1_arburst : s0_arburst;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                if (m_arready) state_d = DATA;
            end
            DATA: begin
                if (r_hs) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    // rlast must coincide exactly with the beat numbered arlen.
                    if (m_rlast != (beat_cnt_q == arlen_q)) err_d = 1'b1;
                    if (m_rlast) begin
                        state_d = IDLE;
`ifndef PIM_ARB_FIXED_PRIO_EN
                        rr_ptr_d = ~owner_q;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= 1'b0;
            owner_q    <= 1'b0;
            beat_cnt_q <= 8'd0;
            err_q      <= 1'b0;
            arid_q     <= '0;
            araddr_q   <= '0;
            arlen_q    <= 8'd0;
            arsize_q   <= 3'd0;
            arburst_q  <= 2'd0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
            arid_q     <= arid_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
            arsize_q   <= arsize_d;
            arburst_q  <= arburst_d;
        end
    end

endmodule

// File: tb/tb_pim_axi_rd_arbiter.sv
// tb_pim_axi_rd_arbiter: directed scenarios with randomized fields, checked against a transaction-level model.
module tb_pim_axi_rd_arbiter;
    localparam int DW = 512;
    localparam int AW = 32;
    localparam int IW = 8;
    localparam int P_WAIT = 0;
    localparam int P_ADDR = 1;
    localparam int P_DATA = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [IW-1:0] s0_arid, s1_arid, m_arid, s0_rid, s1_rid, m_rid;
    logic [AW-1:0] s0_araddr, s1_araddr, m_araddr;
    logic [7:0]    s0_arlen, s1_arlen, m_arlen;
    logic [2:0]    s0_arsize, s1_arsize, m_arsize;
    logic [1:0]    s0_arburst, s1_arburst, m_arburst;
    logic          s0_arvalid, s1_arvalid, m_arvalid, s0_arready, s1_arready, m_arready;
    logic [DW-1:0] s0_rdata, s1_rdata, m_rdata;
    logic [1:0]    s0_rresp, s1_rresp, m_rresp;
    logic          s0_rlast, s1_rlast, m_rlast;
    logic          s0_rvalid, s1_rvalid, m_rvalid, s0_rready, s1_rready, m_rready;
    logic          protocol_err;

    pim_axi_rd_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .s0_arid(s0_arid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize),
        .s0_arburst(s0_arburst), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
        .s0_rid(s0_rid), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast),
        .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
        .s1_arid(s1_arid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize),
        .s1_arburst(s1_arburst), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
        .s1_rid(s1_rid), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast),
        .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .protocol_err(protocol_err)
    );

    int errors = 0;
    int checks = 0;

    // Requester-side pending requests
    logic          req_pend [2];
    logic [IW-1:0] req_id [2];
    logic [AW-1:0] req_addr [2];
    logic [7:0]    req_len [2];
    logic [2:0]    req_size [2];
    logic [1:0]    req_burst [2];
    int            remaining [2];

    // Transaction-level model of the arbiter plus memory
    int            phase;
    logic          pref;
    logic          own;
    logic          err_exp;
    logic [IW-1:0] cur_id;
    logic [AW-1:0] cur_addr;
    logic [7:0]    cur_len;
    logic [2:0]    cur_size;
    logic [1:0]    cur_burst;
    int            mem_beat;
    int            mem_last;
    logic          beat_shown;
    logic [DW-1:0] beat_data;
    logic [1:0]    beat_resp;
    logic [DW-1:0] exp_q[$];
    int            grant_log[$];
    int            beats_done;
    logic          tog;

    // Run configuration
    int            cfg_len;
    int            cfg_addr;
    int            cfg_early;
    int            cfg_rmode;
    bit            cfg_rnd;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic new_req(input int i);
        req_pend[i]  = 1'b1;
        req_id[i]    = IW'($urandom);
        req_addr[i]  = (cfg_addr >= 0) ? AW'(cfg_addr) : AW'($urandom);
        req_len[i]   = (cfg_len >= 0) ? 8'(cfg_len) : 8'($urandom_range(0, 7));
        req_size[i]  = 3'($urandom_range(0, 6));
        req_burst[i] = 2'($urandom_range(0, 2));
    endtask

    task automatic new_beat();
        for (int k = 0; k < DW / 32; k++) beat_data[k*32 +: 32] = $urandom;
        beat_resp = 2'($urandom_range(0, 3));
        exp_q.push_back(beat_data);
    endtask

    task automatic model_reset();
        phase = P_WAIT; pref = 1'b0; own = 1'b0; err_exp = 1'b0; beat_shown = 1'b0;
        mem_beat = 0; mem_last = 0; tog = 1'b0;
        req_pend[0] = 1'b0; req_pend[1] = 1'b0;
        exp_q.delete();
    endtask

    task automatic config_run(input int n0, input int n1, input int flen, input int faddr,
                              input int early, input int rmode, input bit rnd);
        cfg_len = flen; cfg_addr = faddr; cfg_early = early; cfg_rmode = rmode; cfg_rnd = rnd;
        remaining[0] = n0; remaining[1] = n1;
        grant_log.delete();
        beats_done = 0;
        req_pend[0] = 1'b0; req_pend[1] = 1'b0;
        if (n0 > 0) new_req(0);
        if (n1 > 0) new_req(1);
    endtask

    // One clock cycle: drive at negedge, check settled outputs, advance the model at posedge.
    task automatic cycle_step();
        logic exp_w, own_rready, hs_ar, hs_m, hs_r, exp_last;
        logic [DW-1:0] obs_data;
        @(negedge clk);
        s0_arvalid = req_pend[0]; s0_arid = req_id[0]; s0_araddr = req_addr[0];
        s0_arlen = req_len[0]; s0_arsize = req_size[0]; s0_arburst = req_burst[0];
        s1_arvalid = req_pend[1]; s1_arid = req_id[1]; s1_araddr = req_addr[1];
        s1_arlen = req_len[1]; s1_arsize = req_size[1]; s1_arburst = req_burst[1];
        m_arready = cfg_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (phase == P_DATA) begin
            if (!beat_shown) beat_shown = cfg_rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        end else begin
            beat_shown = 1'b0;
        end
        m_rvalid = beat_shown; m_rdata = beat_data; m_rid = cur_id; m_rresp = beat_resp;
        m_rlast = (mem_beat == mem_last);
        case (cfg_rmode)
            0: begin s0_rready = 1'b1; s1_rready = 1'b1; end
            1: begin s0_rready = tog; s1_rready = tog; tog = ~tog; end
            default: begin
                s0_rready = 1'($urandom_range(0, 1));
                s1_rready = 1'($urandom_range(0, 1));
            end
        endcase
        #1;
`ifdef PIM_ARB_FIXED_PRIO_EN
        exp_w = req_pend[0] ? 1'b0 : 1'b1;
`else
        exp_w = (req_pend[0] && req_pend[1]) ? pref : req_pend[1];
`endif
        own_rready = own ? s1_rready : s0_rready;
        chk("s0_arready", s0_arready, phase == P_WAIT && req_pend[0] && exp_w == 1'b0);
        chk("s1_arready", s1_arready, phase == P_WAIT && req_pend[1] && exp_w == 1'b1);
        chk("m_arvalid", m_arvalid, phase == P_ADDR);
        chk("protocol_err", protocol_err, err_exp);
        if (phase == P_ADDR) begin
            chk("m_araddr", m_araddr, cur_addr);
            chk("m_arlen", m_arlen, cur_len);
            chk("m_arid", m_arid, cur_id);
            chk("m_arsize", m_arsize, cur_size);
            chk("m_arburst", m_arburst, cur_burst);
        end
        if (phase == P_DATA) begin
            chk("owner_rvalid", own ? s1_rvalid : s0_rvalid, beat_shown);
            chk("other_rvalid", own ? s0_rvalid : s1_rvalid, 1'b0);
            chk("m_rready", m_rready, own_rready);
        end else begin
            chk("idle_rvalid", {s0_rvalid, s1_rvalid}, 2'b00);
            chk("idle_m_rready", m_rready, 1'b0);
        end
        hs_ar = (phase == P_WAIT) && (req_pend[0] || req_pend[1]);
        hs_m  = (phase == P_ADDR) && m_arready;
        hs_r  = (phase == P_DATA) && beat_shown && own_rready;
        exp_last = (mem_beat == mem_last);
        if (hs_r) begin
            obs_data = own ? s1_rdata : s0_rdata;
            if (exp_q.size() == 0) begin
                chk("exp_q_empty", 1'b1, 1'b0);
            end else begin
                chk("rdata", obs_data, exp_q.pop_front());
            end
            chk("rlast", own ? s1_rlast : s0_rlast, exp_last);
            chk("rid", own ? s1_rid : s0_rid, cur_id);
            chk("rresp", own ? s1_rresp : s0_rresp, beat_resp);
        end
        @(posedge clk);
        if (hs_ar) begin
            own = exp_w;
            grant_log.push_back(int'(exp_w));
            cur_id = req_id[exp_w]; cur_addr = req_addr[exp_w]; cur_len = req_len[exp_w];
            cur_size = req_size[exp_w]; cur_burst = req_burst[exp_w];
            req_pend[exp_w] = 1'b0;
            remaining[exp_w]--;
            if (remaining[exp_w] > 0) new_req(int'(exp_w));
            phase = P_ADDR;
        end else if (hs_m) begin
            phase = P_DATA;
            mem_beat = 0;
            mem_last = (cfg_early >= 0 && cfg_early < int'(cur_len)) ? cfg_early : int'(cur_len);
            new_beat();
        end else if (hs_r) begin
            if ((exp_last && mem_beat != int'(cur_len)) || (!exp_last && mem_beat == int'(cur_len)))
                err_exp = 1'b1;
            beats_done++;
            beat_shown = 1'b0;
            if (exp_last) begin
                phase = P_WAIT;
                pref = ~own;
            end else begin
                mem_beat++;
                new_beat();
            end
        end
    endtask

    task automatic run_until_done(input int ngr);
        int budget;
        budget = 0;
        do begin
            cycle_step();
            budget++;
        end while (!(grant_log.size() == ngr && phase == P_WAIT) && budget < 3000);
        chk("run_completed", budget < 3000, 1'b1);
        req_pend[0] = 1'b0; req_pend[1] = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_arready"}, {s0_arready, s1_arready}, 2'b00);
        chk({tag, "_rvalid"}, {s0_rvalid, s1_rvalid}, 2'b00);
        chk({tag, "_m_arvalid"}, m_arvalid, 1'b0);
        chk({tag, "_m_rready"}, m_rready, 1'b0);
        chk({tag, "_protocol_err"}, protocol_err, 1'b0);
        chk({tag, "_m_araddr"}, m_araddr, '0);
        chk({tag, "_m_arid"}, m_arid, '0);
        chk({tag, "_m_arlen"}, m_arlen, '0);
        chk({tag, "_m_arsize_burst"}, {m_arsize, m_arburst}, '0);
    endtask

    initial begin
        int budget;
        rst_n = 1'b0;
        s0_arvalid = 1'b0; s1_arvalid = 1'b0; s0_rready = 1'b0; s1_rready = 1'b0;
        s0_arid = '0; s0_araddr = '0; s0_arlen = '0; s0_arsize = '0; s0_arburst = '0;
        s1_arid = '0; s1_araddr = '0; s1_arlen = '0; s1_arsize = '0; s1_arburst = '0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rid = '0; m_rresp = '0; m_rlast = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Simultaneous request straight after reset: s0 first, then s1.
        config_run(1, 1, -1, -1, -1, 0, 1'b0);
        run_until_done(2);
        chk("simul_first", grant_log[0], 0);
        chk("simul_second", grant_log[1], 1);

        // Both requesters continuously for six bursts.
        config_run(6, 6, -1, -1, -1, 0, 1'b0);
        run_until_done(6);
        for (int i = 0; i < 6; i++) begin
`ifdef PIM_ARB_FIXED_PRIO_EN
            chk("starve_grant", grant_log[i], 0);
`else
            chk("starve_grant", grant_log[i], i % 2);
`endif
        end

        // Single s0 burst, arlen=3 at 0x100.
        config_run(1, 0, 3, 32'h100, -1, 0, 1'b0);
        run_until_done(1);
        chk("single_owner", grant_log[0], 0);
        chk("single_beats", beats_done, 4);

        // s1 arlen=7 with rready toggling every cycle.
        config_run(0, 1, 7, -1, -1, 1, 1'b0);
        run_until_done(1);
        chk("bp_beats", beats_done, 8);

        // Randomized mixed traffic with memory stalls and random rready.
        config_run(8, 8, -1, -1, -1, 2, 1'b1);
        run_until_done(16);

        // Memory ends an arlen=3 burst after beat 2.
        config_run(1, 0, 3, -1, 1, 0, 1'b0);
        run_until_done(1);
        chk("mismatch_beats", beats_done, 2);
        config_run(0, 0, -1, -1, -1, 0, 1'b0);
        repeat (2) cycle_step();
        config_run(0, 1, -1, -1, -1, 0, 1'b0);
        run_until_done(1);

        // Reset asserted mid-burst.
        config_run(1, 0, 7, -1, -1, 0, 1'b0);
        budget = 0;
        do begin
            cycle_step();
            budget++;
        end while (!(phase == P_DATA && mem_beat >= 2) && budget < 200);
        chk("reach_data", budget < 200, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        s0_arvalid = 1'b0; s1_arvalid = 1'b0;
        m_rvalid = 1'b1; m_arready = 1'b1; s0_rready = 1'b1; s1_rready = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        model_reset();
        m_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        config_run(0, 1, -1, -1, -1, 0, 1'b0);
        run_until_done(1);
        chk("post_reset_owner", grant_log[0], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
